sd_resp_receiver: RTL and testbench

Downstream partner of the SD SPI command shifter: once a 48-bit command has been clocked out on MOSI, this block samples MISO one bit per qualified cycle and finds the response start bit within the NCR window. It captures the 8-bit R1 byte and, on request, the 32-bit trailer of R3/R7, then reports one result pulse to the SD init/read controller. Optionally it also tracks the R1b busy phase.

---
 rtl/sd_resp_receiver.sv | 210 +++++++++++++++++++++
 tb/tb_sd_resp_receiver.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/sd_resp_receiver.sv
// SD SPI response receiver: finds the R1 start bit within the NCR window, captures R1 and the optional
// 32-bit R3/R7 trailer. Define SD_RESP_BUSY_WAIT_EN to also wait out the R1b busy phase.
module sd_resp_receiver #(
    parameter int unsigned MAX_WAIT = 64,
    parameter int unsigned BUSY_MAX = 65535
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        long_resp,
    input  logic        busy_resp,
    input  logic        bit_en,
    input  logic        miso,
    output logic        busy,
    output logic        resp_valid,
    output logic [7:0]  r1,
    output logic [31:0] payload,
    output logic        timeout
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_START,
        S_R1,
        S_PAYLOAD,
        S_BUSY,
        S_DONE
    } state_t;

    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

    state_t      state_q,      state_d;
    logic [7:0]  wait_cnt_q,   wait_cnt_d;
    logic [5:0]  bit_cnt_q,    bit_cnt_d;
    logic        long_q,       long_d;
    logic [7:0]  r1_q,         r1_d;
    logic [31:0] payload_q,    payload_d;
    logic        timeout_q,    timeout_d;
    logic        busy_q,       busy_d;
    logic        resp_valid_q, resp_valid_d;

`ifdef SD_RESP_BUSY_WAIT_EN
    localparam logic [15:0] BUSY_LAST = 16'(BUSY_MAX - 1);

    logic        busy_resp_q, busy_resp_d;
    logic [15:0] busy_cnt_q,  busy_cnt_d;
`else
    // busy_resp has no function in this build; the name keeps the lint unused check quiet.
    logic unused_busy_resp;
    assign unused_busy_resp = busy_resp;
`endif

    // NOTE: every variable driven here gets its default first, so no path can infer a latch.
    always_comb begin
        state_d      = state_q;
        wait_cnt_d   = wait_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        long_d       = long_q;
        r1_d         = r1_q;
        payload_d    = payload_q;
        timeout_d    = timeout_q;
        busy_d       = busy_q;
        resp_valid_d = 1'b0;
`ifdef SD_RESP_BUSY_WAIT_EN
        busy_resp_d  = busy_resp_q;
        busy_cnt_d   = busy_cnt_q;
`endif

        // busy drops on the edge that ends the resp_valid cycle
        if (resp_valid_q) begin
            busy_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                // busy_q is still set during the resp_valid cycle, which blocks a same-cycle re-arm
                if (start && !busy_q) begin
                    state_d    = S_WAIT_START;
                    long_d     = long_resp;
                    wait_cnt_d = '0;
                    bit_cnt_d  = '0;
                    r1_d       = 8'hFF;
                    payload_d  = '0;
                    timeout_d  = 1'b0;
                    busy_d     = 1'b1;
`ifdef SD_RESP_BUSY_WAIT_EN
                    busy_resp_d = busy_resp;
                    busy_cnt_d  = '0;
`endif
                end
            end

            S_WAIT_START: begin
                if (bit_en) begin
                    if (!miso) begin
                        r1_d      = {r1_q[6:0], 1'b0};
                        bit_cnt_d = 6'd7;
                        state_d   = S_R1;
                    end else if (wait_cnt_q == WAIT_LAST) begin
                        r1_d      = 8'hFF;
                        timeout_d = 1'b1;
                        state_d   = S_DONE;
                    end else begin
                        wait_cnt_d = wait_cnt_q + 8'd1;
                    end
                end
            end

            S_R1: begin
                if (bit_en) begin
                    r1_d = {r1_q[6:0], miso};
                    if (bit_cnt_q == 6'd1) begin
                        if (long_q) begin
                            bit_cnt_d = 6'd32;
                            state_d   = S_PAYLOAD;
`ifdef SD_RESP_BUSY_WAIT_EN
                        end else if (busy_resp_q) begin
                            state_d = S_BUSY;
`endif
                        end else begin
                            state_d = S_DONE;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q - 6'd1;
                    end
                end
            end

            S_PAYLOAD: begin
                if (bit_en) begin
                    payload_d = {payload_q[30:0], miso};
                    if (bit_cnt_q == 6'd1) begin
                        state_d = S_DONE;
                    end else begin
                        bit_cnt_d = bit_cnt_q - 6'd1;
                    end
                end
            end

`ifdef SD_RESP_BUSY_WAIT_EN
            S_BUSY: begin
                if (bit_en) begin
                    if (miso) begin
                        state_d = S_DONE;
                    end else if (busy_cnt_q == BUSY_LAST) begin
                        timeout_d = 1'b1;
                        state_d   = S_DONE;
                    end else begin
                        busy_cnt_d = busy_cnt_q + 16'd1;
                    end
                end
            end
`endif

            S_DONE: begin
                resp_valid_d = 1'b1;
                state_d      = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            wait_cnt_q   <= '0;
            bit_cnt_q    <= '0;
            long_q       <= 1'b0;
            r1_q         <= 8'hFF;
            payload_q    <= '0;
            timeout_q    <= 1'b0;
            busy_q       <= 1'b0;
            resp_valid_q <= 1'b0;
`ifdef SD_RESP_BUSY_WAIT_EN
            busy_resp_q  <= 1'b0;
            busy_cnt_q   <= '0;
`endif
        end else begin
            state_q      <= state_d;
            wait_cnt_q   <= wait_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            long_q       <= long_d;
            r1_q         <= r1_d;
            payload_q    <= payload_d;
            timeout_q    <= timeout_d;
            busy_q       <= busy_d;
            resp_valid_q <= resp_valid_d;
`ifdef SD_RESP_BUSY_WAIT_EN
            busy_resp_q  <= busy_resp_d;
            busy_cnt_q   <= busy_cnt_d;
`endif
        end
    end

    assign busy       = busy_q;
    assign resp_valid = resp_valid_q;
    assign r1         = r1_q;
    assign payload    = payload_q;
    assign timeout    = timeout_q;

`ifndef SYNTHESIS
    a_valid_in_busy : assert property (@(posedge clk) disable iff (rst) resp_valid |-> busy);
    a_valid_pulse   : assert property (@(posedge clk) disable iff (rst) resp_valid |=> !resp_valid);
`endif

endmodule

// File: tb/tb_sd_resp_receiver.sv
// Scoreboard bench for sd_resp_receiver: expected results queued at start, compared on resp_valid.
module tb_sd_resp_receiver;

    localparam int MAX_WAIT = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        long_resp;
    logic        busy_resp;
    logic        bit_en;
    logic        miso;
    logic        busy;
    logic        resp_valid;
    logic [7:0]  r1;
    logic [31:0] payload;
    logic        timeout;

    typedef struct {
        logic [7:0]  r1;
        logic [31:0] payload;
        logic        timeout;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    sd_resp_receiver #(.MAX_WAIT(MAX_WAIT), .BUSY_MAX(65535)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .long_resp  (long_resp),
        .busy_resp  (busy_resp),
        .bit_en     (bit_en),
        .miso       (miso),
        .busy       (busy),
        .resp_valid (resp_valid),
        .r1         (r1),
        .payload    (payload),
        .timeout    (timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, expv);
        end
    endtask

    // Scoreboard side: every resp_valid pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!rst && resp_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_valid", 32'(resp_valid), 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("sb_r1", 32'(r1), 32'(e.r1));
                check("sb_payload", payload, e.payload);
                check("sb_timeout", 32'(timeout), 32'(e.timeout));
                check("sb_busy_at_valid", 32'(busy), 32'd1);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One qualified sample, then gap cycles with bit_en low and MISO scrambled.
    task automatic drive_bit(input logic b, input int gap);
        bit_en = 1'b1;
        miso   = b;
        tick();
        bit_en = 1'b0;
        for (int i = 0; i < gap; i++) begin
            miso = 1'($urandom_range(0, 1));
            tick();
        end
        miso = 1'b1;
    endtask

    task automatic run_txn(input string name, input int ones, input logic [7:0] r1v,
                           input logic lr, input logic [31:0] pl, input logic br, input int zeros,
                           input int r1_gap, input bit restart_mid, input bit start_at_valid);
        exp_t e;
        bit   wait_busy;
        bit   is_to;
`ifdef SD_RESP_BUSY_WAIT_EN
        wait_busy = br && !lr;
`else
        wait_busy = 1'b0;
`endif
        is_to = (ones >= MAX_WAIT);
        if (is_to) begin
            e.r1 = 8'hFF; e.payload = 32'h0; e.timeout = 1'b1;
        end else begin
            e.r1 = r1v; e.payload = lr ? pl : 32'h0; e.timeout = 1'b0;
        end
        exp_q.push_back(e);

        start = 1'b1; long_resp = lr; busy_resp = br;
        tick();
        start = 1'b0; long_resp = 1'b0; busy_resp = 1'b0;
        check({name, ":busy_rise"}, 32'(busy), 32'd1);

        if (is_to) begin
            for (int i = 0; i < MAX_WAIT; i++) drive_bit(1'b1, 0);
        end else begin
            for (int i = 0; i < ones; i++) drive_bit(1'b1, 0);
            if (restart_mid) begin
                start = 1'b1; long_resp = ~lr; busy_resp = 1'b0;
                tick();
                start = 1'b0; long_resp = 1'b0;
            end
            for (int i = 7; i >= 0; i--) begin
                drive_bit(r1v[i], (i == 0 && !lr && !wait_busy) ? 0 : r1_gap);
            end
            if (lr) for (int i = 31; i >= 0; i--) drive_bit(pl[i], 0);
            if (wait_busy) begin
                for (int i = 0; i < zeros; i++) drive_bit(1'b0, 0);
                drive_bit(1'b1, 0);
            end
        end

        check({name, ":no_early_valid"}, 32'(resp_valid), 32'd0);
        tick();
        check({name, ":valid_latency"}, 32'(resp_valid), 32'd1);
        if (start_at_valid) begin
            start = 1'b1; long_resp = 1'b1;
        end
        tick();
        start = 1'b0; long_resp = 1'b0;
        check({name, ":valid_pulse"}, 32'(resp_valid), 32'd0);
        check({name, ":busy_fall"}, 32'(busy), 32'd0);

        // Without busy tracking, the R1b busy tail arrives while the receiver is idle.
        if (br && !lr && !wait_busy) begin
            for (int i = 0; i < zeros; i++) drive_bit(1'b0, 0);
            drive_bit(1'b1, 0);
            repeat (3) tick();
            check({name, ":idle_after_tail"}, 32'(busy), 32'd0);
        end
        repeat (2) tick();
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, ":busy"}, 32'(busy), 32'd0);
        check({name, ":resp_valid"}, 32'(resp_valid), 32'd0);
        check({name, ":r1"}, 32'(r1), 32'h0000_00FF);
        check({name, ":payload"}, payload, 32'd0);
        check({name, ":timeout"}, 32'(timeout), 32'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; long_resp = 1'b0; busy_resp = 1'b0; bit_en = 1'b0; miso = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check_reset_outputs("reset");

        run_txn("r1_basic",   5, 8'h01, 1'b0, 32'h0,         1'b0, 0,  0, 1'b0, 1'b0);
        run_txn("wait_to",    MAX_WAIT, 8'h00, 1'b0, 32'h0,  1'b0, 0,  0, 1'b0, 1'b0);
        run_txn("wait_edge",  MAX_WAIT - 1, 8'h05, 1'b0, 32'h0, 1'b0, 0, 0, 1'b0, 1'b0);
        run_txn("r7",         3, 8'h01, 1'b1, 32'h0000_01AA, 1'b0, 0,  0, 1'b0, 1'b0);
        run_txn("r1b",        2, 8'h00, 1'b0, 32'h0,         1'b1, 10, 0, 1'b0, 1'b0);
        run_txn("r1_gapped",  5, 8'h01, 1'b0, 32'h0,         1'b0, 0,  2, 1'b0, 1'b0);
        run_txn("restart",    4, 8'h25, 1'b0, 32'h0,         1'b0, 0,  0, 1'b1, 1'b1);
        run_txn("r3",         0, 8'h00, 1'b1, 32'hC0FF_8000, 1'b1, 4,  1, 1'b0, 1'b0);

        // Reset in the middle of a long response: no pulse, outputs back to reset values.
        start = 1'b1; long_resp = 1'b1;
        tick();
        start = 1'b0; long_resp = 1'b0;
        drive_bit(1'b1, 0);
        for (int i = 7; i >= 0; i--) drive_bit(1'(8'h01 >> i), 0);
        for (int i = 0; i < 10; i++) drive_bit(1'(i & 1), 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset_outputs("mid_rst");
        bit_en = 1'b1; miso = 1'b1;
        repeat (40) tick();
        bit_en = 1'b0;
        check("mid_rst:still_idle", 32'(busy), 32'd0);

        run_txn("after_rst",  1, 8'h01, 1'b1, 32'h1234_5678, 1'b0, 0, 0, 1'b0, 1'b0);

        repeat (5) tick();
        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Hard bound so a hung DUT still ends the run.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
